// File: rtl/fc_layer_seq_if.sv
// Bus bundle for the fully-connected layer engine: sequencer handshake,
// runtime layer configuration and the four SRAM ports.
//
// Handshake: start is a one-cycle request that is honoured only while the
// engine is idle. busy rises the cycle after an accepted start and stays high
// through the done cycle. done pulses once per accepted start, and err
// pulses with it when a dimension was zero. SRAM reads carry no
// valid/ready. The engine drives an address in cycle t and samples rdata at
// the end of cycle t+RD_LAT, so the memory side must hold rdata valid for
// that whole cycle. The output SRAM write is a single-cycle wea strobe with
// addr/wdata.
interface fc_layer_seq_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DIM_WIDTH  = 10
);
    logic                         start;
    logic [DIM_WIDTH-1:0]         fc_in;
    logic [DIM_WIDTH-1:0]         fc_out;
    logic [ADDR_WIDTH-1:0]        in_base;
    logic [ADDR_WIDTH-1:0]        w_base;
    logic [ADDR_WIDTH-1:0]        b_base;
    logic [ADDR_WIDTH-1:0]        out_base;
    logic                         busy;
    logic                         done;
    logic                         err;
    logic [ADDR_WIDTH-1:0]        sram_input_addr;
    logic signed [DATA_WIDTH-1:0] sram_input_rdata;
    logic [ADDR_WIDTH-1:0]        sram_weight_addr;
    logic signed [DATA_WIDTH-1:0] sram_weight_rdata;
    logic [ADDR_WIDTH-1:0]        sram_bias_addr;
    logic signed [DATA_WIDTH-1:0] sram_bias_rdata;
    logic                         sram_output_wea;
    logic [ADDR_WIDTH-1:0]        sram_output_addr;
    logic signed [DATA_WIDTH-1:0] sram_output_wdata;
    logic [2:0]                   dbg_state;

    // Sequencer / memory side
    modport master (
        output start, fc_in, fc_out, in_base, w_base, b_base, out_base,
        output sram_input_rdata, sram_weight_rdata, sram_bias_rdata,
        input  busy, done, err,
        input  sram_input_addr, sram_weight_addr, sram_bias_addr,
        input  sram_output_wea, sram_output_addr, sram_output_wdata,
        input  dbg_state
    );

    // Engine side
    modport slave (
        input  start, fc_in, fc_out, in_base, w_base, b_base, out_base,
        input  sram_input_rdata, sram_weight_rdata, sram_bias_rdata,
        output busy, done, err,
        output sram_input_addr, sram_weight_addr, sram_bias_addr,
        output sram_output_wea, sram_output_addr, sram_output_wdata,
        output dbg_state
    );
endinterface

// File: rtl/fc_layer_seq.sv
// Fully-connected layer engine: y[o] = sat(bias[o] + sum_i (x[i]*w[o][i]) >>> FRAC_BITS).
// One neuron at a time: fc_in MAC read cycles, RD_LAT drain cycles, one write.
// Optional feature macro FC_RELU_EN: clamps negative saturated results to 0.
// The interface instance must use the same ADDR/DATA/DIM widths as this module.
// ACC_WIDTH must not exceed 2*DATA_WIDTH.
module fc_layer_seq #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DIM_WIDTH  = 10,
    parameter int FRAC_BITS  = 24,
    parameter int ACC_WIDTH  = 48,
    parameter int RD_LAT     = 2
) (
    input logic          clk,
    input logic          rst,
    fc_layer_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAC   = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    state_t                       state;
    logic [DIM_WIDTH-1:0]         fc_in_q, fc_out_q, i_cnt, o_cnt;
    logic [ADDR_WIDTH-1:0]        in_base_q, b_base_q, out_base_q, w_ptr;
    logic [1:0]                   drain_cnt;
    logic [ADDR_WIDTH-1:0]        in_addr, w_addr, b_addr, out_addr;
    logic                         out_wea, busy_q, done_q, err_q;
    logic signed [DATA_WIDTH-1:0] wdata_q;
    // Issue markers delayed by the SRAM latency; bit RD_LAT-1 marks the
    // cycle in which the matching rdata is valid.
    logic [RD_LAT-1:0]            x_vld, b_vld;
    logic signed [ACC_WIDTH-1:0]  acc, acc_next, prod_ext, bias_ext;
    logic signed [2*DATA_WIDTH-1:0] x_ext, w_ext, prod, prod_sh;
    logic signed [DATA_WIDTH-1:0] result;

    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.err               = err_q;
    assign bus.sram_input_addr   = in_addr;
    assign bus.sram_weight_addr  = w_addr;
    assign bus.sram_bias_addr    = b_addr;
    assign bus.sram_output_wea   = out_wea;
    assign bus.sram_output_addr  = out_addr;
    assign bus.sram_output_wdata = wdata_q;
    assign bus.dbg_state         = state;

    // Product/bias alignment, next accumulator value and saturated result
    always_comb begin
        x_ext    = {{DATA_WIDTH{bus.sram_input_rdata[DATA_WIDTH-1]}}, bus.sram_input_rdata};
        w_ext    = {{DATA_WIDTH{bus.sram_weight_rdata[DATA_WIDTH-1]}}, bus.sram_weight_rdata};
        prod     = x_ext * w_ext;
        prod_sh  = prod >>> FRAC_BITS;
        prod_ext = prod_sh[ACC_WIDTH-1:0];
        bias_ext = {{(ACC_WIDTH-DATA_WIDTH){bus.sram_bias_rdata[DATA_WIDTH-1]}},
                    bus.sram_bias_rdata};
        acc_next = acc;
        if (x_vld[RD_LAT-1]) acc_next = acc_next + prod_ext;
        if (b_vld[RD_LAT-1]) acc_next = acc_next + bias_ext;
        if (acc_next > SAT_MAX)      result = SAT_MAX[DATA_WIDTH-1:0];
        else if (acc_next < SAT_MIN) result = SAT_MIN[DATA_WIDTH-1:0];
        else                         result = acc_next[DATA_WIDTH-1:0];
`ifdef FC_RELU_EN
        if (result[DATA_WIDTH-1]) result = '0;
`endif
    end

    // Control FSM, address generation, read-latency tracking and accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            fc_in_q    <= '0;
            fc_out_q   <= '0;
            i_cnt      <= '0;
            o_cnt      <= '0;
            in_base_q  <= '0;
            b_base_q   <= '0;
            out_base_q <= '0;
            w_ptr      <= '0;
            drain_cnt  <= '0;
            in_addr    <= '0;
            w_addr     <= '0;
            b_addr     <= '0;
            out_addr   <= '0;
            out_wea    <= 1'b0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            x_vld      <= '0;
            b_vld      <= '0;
            acc        <= '0;
        end else begin
            x_vld[0] <= (state == S_MAC);
            b_vld[0] <= (state == S_MAC) && (i_cnt == '0);
            for (int k = 1; k < RD_LAT; k++) begin
                x_vld[k] <= x_vld[k-1];
                b_vld[k] <= b_vld[k-1];
            end
            if (x_vld[RD_LAT-1] || b_vld[RD_LAT-1]) acc <= acc_next;

            // Read addresses are only non-zero in MAC; write strobes are single-cycle.
            in_addr  <= '0;
            w_addr   <= '0;
            b_addr   <= '0;
            out_addr <= '0;
            out_wea  <= 1'b0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        fc_in_q    <= bus.fc_in;
                        fc_out_q   <= bus.fc_out;
                        in_base_q  <= bus.in_base;
                        b_base_q   <= bus.b_base;
                        out_base_q <= bus.out_base;
                        busy_q     <= 1'b1;
                        i_cnt      <= '0;
                        o_cnt      <= '0;
                        acc        <= '0;
                        if (bus.fc_in == '0 || bus.fc_out == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            state   <= S_MAC;
                            in_addr <= bus.in_base;
                            w_addr  <= bus.w_base;
                            w_ptr   <= bus.w_base + 1'b1;
                            b_addr  <= bus.b_base;
                        end
                    end
                end
                S_MAC: begin
                    if (i_cnt == fc_in_q - 1'b1) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        // Weight rows are contiguous, so one running pointer
                        // covers w_base + o*fc_in + i across all neurons.
                        i_cnt   <= i_cnt + 1'b1;
                        in_addr <= in_addr + 1'b1;
                        w_addr  <= w_ptr;
                        w_ptr   <= w_ptr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == 2'(RD_LAT - 1)) begin
                        state    <= S_WRITE;
                        out_wea  <= 1'b1;
                        out_addr <= out_base_q + ADDR_WIDTH'(o_cnt);
                        wdata_q  <= result;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (o_cnt == fc_out_q - 1'b1) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end else begin
                        state   <= S_MAC;
                        o_cnt   <= o_cnt + 1'b1;
                        i_cnt   <= '0;
                        acc     <= '0;
                        in_addr <= in_base_q;
                        w_addr  <= w_ptr;
                        w_ptr   <= w_ptr + 1'b1;
                        b_addr  <= b_base_q + ADDR_WIDTH'(o_cnt + 1'b1);
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_layer_seq.sv
// Self-checking bench for fc_layer_seq: SRAM models with read latency,
// an arithmetic reference model of the layer, and directed plus random runs.
module tb_fc_layer_seq;
    localparam int AW = 16, DW = 32, NW = 10, FRAC = 24, ACCW = 48, RD_LAT = 2;
    localparam longint SMAX = (longint'(1) <<< 31) - 1;
    localparam longint SMIN = -(longint'(1) <<< 31);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fc_layer_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DIM_WIDTH(NW)) bus_if();

    fc_layer_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DIM_WIDTH(NW),
                   .FRAC_BITS(FRAC), .ACC_WIDTH(ACCW), .RD_LAT(RD_LAT))
        dut (.clk(clk), .rst(rst), .bus(bus_if));

    // ---------------- clock counter and SRAM models ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [DW-1:0] mem_x[65536], mem_w[65536], mem_b[65536];
    logic [AW-1:0] hx[8], hw[8], hb[8];

    // Address seen in cycle c is answered with data during cycle c+RD_LAT.
    always @(negedge clk) begin
        hx[cyc % 8] = bus_if.sram_input_addr;
        hw[cyc % 8] = bus_if.sram_weight_addr;
        hb[cyc % 8] = bus_if.sram_bias_addr;
        bus_if.sram_input_rdata  = mem_x[hx[(cyc + 8 - RD_LAT) % 8]];
        bus_if.sram_weight_rdata = mem_w[hw[(cyc + 8 - RD_LAT) % 8]];
        bus_if.sram_bias_rdata   = mem_b[hb[(cyc + 8 - RD_LAT) % 8]];
    end

    // ---------------- monitor ----------------
    logic [63:0] obs_q[$];
    logic [63:0] exp_q[$];
    int   run_c0 = 0;
    int   done_cnt, done_cyc, done_err, err_stray;
    logic busy_log[1024];
    logic [47:0] addr_trace[16];
    int   exp_done;
    int   exp_err;
    int   errors = 0;
    int   checks = 0;

    always @(negedge clk) begin
        int rel;
        rel = cyc - run_c0;
        if (bus_if.sram_output_wea)
            obs_q.push_back({16'(rel), bus_if.sram_output_addr, bus_if.sram_output_wdata});
        if (bus_if.done) begin
            done_cnt++;
            done_cyc = rel;
            done_err = int'(bus_if.err);
        end
        if (bus_if.err && !bus_if.done) err_stray++;
        if (rel >= 0 && rel < 1024) busy_log[rel] = bus_if.busy;
        if (rel >= 0 && rel < 16)
            addr_trace[rel] = {bus_if.sram_input_addr, bus_if.sram_weight_addr, bus_if.sram_bias_addr};
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] obs_at(input int k);
        return (k < obs_q.size()) ? obs_q[k] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic logic signed [DW-1:0] rand_data();
        logic signed [DW-1:0] v;
        v = $urandom;
        return v >>> $urandom_range(0, 10);
    endfunction

    task automatic fill_rand(input int fi, fo, input logic [AW-1:0] ib, wb, bb);
        logic [AW-1:0] a;
        for (int i = 0; i < fi; i++) begin a = ib + AW'(i); mem_x[a] = rand_data(); end
        for (int i = 0; i < fi * fo; i++) begin a = wb + AW'(i); mem_w[a] = rand_data(); end
        for (int o = 0; o < fo; o++) begin a = bb + AW'(o); mem_b[a] = rand_data(); end
    endtask

    // Reference: plain fixed-point arithmetic on the memory contents.
    task automatic build_expect(input int fi, fo, input logic [AW-1:0] ib, wb, bb, ob);
        longint acc;
        logic [DW-1:0] y;
        logic [AW-1:0] ax, aw, ab, ao;
        int p;
        exp_q.delete();
        p = fi + RD_LAT + 1;
        exp_err  = (fi == 0 || fo == 0) ? 1 : 0;
        exp_done = (exp_err == 1) ? 1 : fo * p + 1;
        if (exp_err == 0) begin
            for (int o = 0; o < fo; o++) begin
                ab  = bb + AW'(o);
                acc = longint'(mem_b[ab]);
                for (int i = 0; i < fi; i++) begin
                    ax = ib + AW'(i);
                    aw = wb + AW'(o * fi + i);
                    acc += (longint'(mem_x[ax]) * longint'(mem_w[aw])) >>> FRAC;
                end
                if (acc > SMAX)      y = 32'h7FFF_FFFF;
                else if (acc < SMIN) y = 32'h8000_0000;
                else                 y = acc[31:0];
`ifdef FC_RELU_EN
                if (y[31]) y = '0;
`endif
                ao = ob + AW'(o);
                exp_q.push_back({16'(p * (o + 1)), ao, y});
            end
        end
    endtask

    task automatic kick(input int fi, fo, input logic [AW-1:0] ib, wb, bb, ob);
        @(negedge clk);
        obs_q.delete();
        done_cnt = 0; done_cyc = -1; done_err = 0; err_stray = 0;
        for (int k = 0; k < 1024; k++) busy_log[k] = 1'bx;
        run_c0 = cyc;
        bus_if.fc_in = NW'(fi);  bus_if.fc_out = NW'(fo);
        bus_if.in_base = ib;     bus_if.w_base = wb;
        bus_if.b_base = bb;      bus_if.out_base = ob;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    task automatic check_run();
        chk("write_count", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            chk($sformatf("write%0d", k), obs_at(k), exp_q[k]);
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("done_cycle", 64'(done_cyc), 64'(exp_done));
        chk("done_err", 64'(done_err), 64'(exp_err));
        chk("err_stray", 64'(err_stray), 64'd0);
        chk("busy_first", 64'(busy_log[1]), 64'd1);
        chk("busy_done", 64'(busy_log[exp_done]), 64'd1);
        chk("busy_after", 64'(busy_log[exp_done + 1]), 64'd0);
        chk("idle_addr", {16'd0, bus_if.sram_input_addr, bus_if.sram_weight_addr,
                          bus_if.sram_bias_addr}, 64'd0);
    endtask

    task automatic run_layer(input int fi, fo, input logic [AW-1:0] ib, wb, bb, ob,
                             input bit perturb);
        int p, budget;
        build_expect(fi, fo, ib, wb, bb, ob);
        p = fi + RD_LAT + 1;
        budget = exp_done + 6;
        kick(fi, fo, ib, wb, bb, ob);
        for (int k = 2; k <= budget; k++) begin
            @(negedge clk);
            bus_if.start = 1'b0;
            if (perturb && (k == 3 || k == p + 2 || k == exp_done)) begin
                bus_if.start    = 1'b1;
                bus_if.fc_in    = NW'($urandom_range(1, 20));
                bus_if.fc_out   = NW'($urandom_range(1, 20));
                bus_if.in_base  = AW'($urandom);
                bus_if.w_base   = AW'($urandom);
                bus_if.b_base   = AW'($urandom);
                bus_if.out_base = AW'($urandom);
            end
        end
        #1;
        check_run();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [63:0] word;
        logic [31:0] want;
        int fi, fo;
        logic [AW-1:0] ib, wb, bb, ob;

        for (int k = 0; k < 65536; k++) begin mem_x[k] = '0; mem_w[k] = '0; mem_b[k] = '0; end
        for (int k = 0; k < 8; k++) begin hx[k] = '0; hw[k] = '0; hb[k] = '0; end
        bus_if.start = 1'b0; bus_if.fc_in = '0; bus_if.fc_out = '0;
        bus_if.in_base = '0; bus_if.w_base = '0; bus_if.b_base = '0; bus_if.out_base = '0;
        bus_if.sram_input_rdata = '0; bus_if.sram_weight_rdata = '0; bus_if.sram_bias_rdata = '0;

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus_if.busy), 64'd0);
        chk("rst_done_err", {62'd0, bus_if.done, bus_if.err}, 64'd0);
        chk("rst_wea", 64'(bus_if.sram_output_wea), 64'd0);
        chk("rst_rd_addr", {16'd0, bus_if.sram_input_addr, bus_if.sram_weight_addr,
                            bus_if.sram_bias_addr}, 64'd0);
        chk("rst_wr", {bus_if.sram_output_addr, bus_if.sram_output_wdata}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic: 1.0 * 0.5 summed over 4 inputs = 2.0
        for (int i = 0; i < 4; i++) mem_x[16'h0100 + i] = 32'h0100_0000;
        for (int i = 0; i < 8; i++) mem_w[16'h0200 + i] = 32'h0080_0000;
        mem_b[16'h0300] = '0; mem_b[16'h0301] = '0;
        run_layer(4, 2, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b0);
        chk("basic_w0", obs_at(0), {16'd7, 16'h0400, 32'h0200_0000});
        chk("basic_w1", obs_at(1), {16'd14, 16'h0401, 32'h0200_0000});
        chk("basic_done", 64'(done_cyc), 64'd15);
        chk("addr_c1", 64'(addr_trace[1]), {16'd0, 16'h0100, 16'h0200, 16'h0300});
        chk("addr_c2", 64'(addr_trace[2]), {16'd0, 16'h0101, 16'h0201, 16'h0000});
        chk("addr_c8", 64'(addr_trace[8]), {16'd0, 16'h0100, 16'h0204, 16'h0301});

        // Saturation, positive and negative
        mem_x[16'h1000] = 32'h7F00_0000; mem_w[16'h2000] = 32'h7F00_0000; mem_b[16'h3000] = '0;
        run_layer(1, 1, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 1'b0);
        word = obs_at(0);
        chk("sat_pos", 64'(word[31:0]), 64'h7FFF_FFFF);
        mem_x[16'h1000] = 32'h8100_0000;
        run_layer(1, 1, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 1'b0);
        word = obs_at(0);
`ifdef FC_RELU_EN
        want = 32'h0000_0000;
`else
        want = 32'h8000_0000;
`endif
        chk("sat_neg", 64'(word[31:0]), 64'(want));

        // Negative bias only: ReLU decides
        mem_x[16'h5000] = rand_data(); mem_x[16'h5001] = rand_data();
        mem_w[16'h6000] = '0; mem_w[16'h6001] = '0;
        mem_b[16'h7000] = 32'hFF00_0000;
        run_layer(2, 1, 16'h5000, 16'h6000, 16'h7000, 16'h8000, 1'b0);
        word = obs_at(0);
`ifdef FC_RELU_EN
        want = 32'h0000_0000;
`else
        want = 32'hFF00_0000;
`endif
        chk("relu", 64'(word[31:0]), 64'(want));

        // Zero dimensions
        run_layer(3, 0, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 1'b0);
        run_layer(0, 2, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 1'b0);

        // Reset during neuron 1 MAC (P = 11, neuron 1 MAC spans cycles 12..19)
        fi = 8; fo = 3; ib = 16'hFFFC; wb = 16'h0A00; bb = 16'h0B00; ob = 16'h0C00;
        fill_rand(fi, fo, ib, wb, bb);
        build_expect(fi, fo, ib, wb, bb, ob);
        kick(fi, fo, ib, wb, bb, ob);
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 64'(bus_if.busy), 64'd0);
        chk("midrst_wea", 64'(bus_if.sram_output_wea), 64'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("midrst_writes", 64'(obs_q.size()), 64'd1);
        chk("midrst_w0", obs_at(0), exp_q[0]);
        chk("midrst_idle", 64'(bus_if.busy), 64'd0);
        run_layer(fi, fo, ib, wb, bb, ob, 1'b0);

        // Start re-pulsed and configuration changed while busy
        fi = 5; fo = 3; ib = 16'h2100; wb = 16'hFFF8; bb = 16'h2300; ob = 16'hFFFF;
        fill_rand(fi, fo, ib, wb, bb);
        run_layer(fi, fo, ib, wb, bb, ob, 1'b1);

        // Random configurations
        repeat (6) begin
            fi = $urandom_range(1, 12); fo = $urandom_range(1, 5);
            ib = AW'($urandom); wb = AW'($urandom); bb = AW'($urandom); ob = AW'($urandom);
            fill_rand(fi, fo, ib, wb, bb);
            run_layer(fi, fo, ib, wb, bb, ob, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
